// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage with single-cycle ALU ops and a WIDTH-step
// shift-add multiplier sharing one valid/ready output slot.
// Optional feature macro: ALU_OVF_DETECT_EN (signed overflow for add/sub).
// When the macro is undefined the overflow output is tied to 0.
//
// state  | meaning
// S_IDLE | accepting operations; output slot may hold a result
// S_MUL  | iterating shift-add multiply; inputs ignored
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUoperation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       rd_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_mul_rd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [4:0]       r_rd;
  logic             r_ovf;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = (ALUoperation == 4'b1000);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_acc_nxt = r_acc + (r_b[r_cnt] ? (r_a << r_cnt) : '0);

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_slt  = ($signed(a) < $signed(b));

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign rd_out    = r_rd;
  assign overflow  = r_ovf;

  // Single-cycle ALU result and optional signed-overflow flag.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (ALUoperation)
      4'b0000: w_alu_res = a & b;
      4'b0001: w_alu_res = a | b;
      4'b0010: w_alu_res = w_sum;
      4'b0110: w_alu_res = w_diff;
      4'b0111: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      4'b1100: w_alu_res = ~(a | b);
      default: w_alu_res = '0;
    endcase
`ifdef ALU_OVF_DETECT_EN
    if (ALUoperation == 4'b0010)
      w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    else if (ALUoperation == 4'b0110)
      w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: enter MUL on an accepted multiply, leave after the last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplier datapath and the shared output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mul_rd    <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rd        <= '0;
      r_ovf       <= 1'b0;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result    <= w_acc_nxt;
        r_zero      <= (w_acc_nxt == '0);
        r_rd        <= r_mul_rd;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_a         <= a;
        r_b         <= b;
        r_mul_rd    <= rd_in;
        r_cnt       <= '0;
        r_acc       <= '0;
        // accept implies the slot was empty or draining this edge
        r_out_valid <= 1'b0;
      end else begin
        r_result    <= w_alu_res;
        r_zero      <= (w_alu_res == '0);
        r_rd        <= rd_in;
        r_ovf       <= w_alu_ovf;
        r_out_valid <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
